// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: predictor lookup/redirect, instruction memory request/response
// and the decode-side valid/ready head of the fetch FIFO.
interface fetch_queue_if;
  logic [31:0] if_pc;
  logic        if_pred_branch;
  logic        if_pred_taken;
  logic [31:0] if_pred_npc;
  logic        flush;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_pred_branch;
  logic        id_pred_taken;
  logic [31:0] id_pred_npc;

  modport master (
    output if_pc, imem_en,
    output id_valid, id_pc, id_inst, id_pred_branch, id_pred_taken, id_pred_npc,
    input  if_pred_branch, if_pred_taken, if_pred_npc, flush, imem_rdata, id_ready
  );

  modport slave (
    input  if_pc, imem_en,
    input  id_valid, id_pc, id_inst, id_pred_branch, id_pred_taken, id_pred_npc,
    output if_pred_branch, if_pred_taken, if_pred_npc, flush, imem_rdata, id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, tracks one in-flight ROM read and
// queues fetched words with their prediction metadata for decode.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.master  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [PW-1:0] PTR_ONE   = 1;
  localparam logic [CW-1:0] CNT_ONE   = 1;
  localparam logic [CW:0]   OCC_LIMIT = DEPTH[CW:0];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        branch;
    logic        taken;
    logic [31:0] npc;
  } entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        branch;
    logic        taken;
    logic [31:0] npc;
  } inflight_t;

  logic [31:0]   pc_q, pc_d;
  inflight_t     inf_q, inf_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;
  entry_t        head;

  // Occupancy counts the outstanding read so a response always finds a free slot.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inf_q.valid};
    issue     = !rst && !bus.flush && (occupancy < OCC_LIMIT);
    push      = inf_q.valid && !bus.flush;
    pop       = bus.id_valid && bus.id_ready;
  end

  always_comb begin
    // NOTE: every _d signal gets a default first so no path can infer a latch.
    pc_d       = pc_q;
    inf_d      = inf_q;
    inf_d.valid = 1'b0;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (bus.flush) begin
      // Predictor already muxes the EX redirect onto if_pred_npc.
      pc_d     = bus.if_pred_npc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        inf_d = '{valid:  1'b1,
                  pc:     pc_q,
                  branch: bus.if_pred_branch,
                  taken:  bus.if_pred_taken,
                  npc:    bus.if_pred_npc};
        pc_d  = bus.if_pred_npc;
      end
      if (push) begin
        mem_d[wr_ptr_q] = '{pc:     inf_q.pc,
                            inst:   bus.imem_rdata,
                            branch: inf_q.branch,
                            taken:  inf_q.taken,
                            npc:    inf_q.npc};
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) begin
      pc_q     <= RESET_PC;
      inf_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      inf_q    <= inf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; count_q gates every read, so stale words stay invisible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head              = mem_q[rd_ptr_q];
    bus.if_pc         = pc_q;
    bus.imem_en       = issue;
    bus.id_valid      = (count_q != '0);
    bus.id_pc          = '0;
    bus.id_inst        = '0;
    bus.id_pred_branch = 1'b0;
    bus.id_pred_taken  = 1'b0;
    bus.id_pred_npc    = '0;
    if (bus.id_valid) begin
      bus.id_pc          = head.pc;
      bus.id_inst        = head.inst;
      bus.id_pred_branch = head.branch;
      bus.id_pred_taken  = head.taken;
      bus.id_pred_npc    = head.npc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: sequential fetch, taken prediction, backpressure,
// pointer wrap, flush and reset-with-flush, using a ROM and predictor model.
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
  localparam logic [31:0] TAKEN_PC  = 32'hBFC0_0010;
  localparam logic [31:0] TAKEN_TGT = 32'hBFC0_0100;
  localparam logic [31:0] FLUSH_TGT = 32'hBFC0_0200;

  logic        clk;
  logic        rst;
  logic [31:0] flush_npc;
  int          checks;
  int          failures;
  int          n_issue;

  fetch_queue_if bus ();

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, a[31:16]};
  endfunction

  // Predictor model: fall-through pc+4, one taken branch, redirect target on flush.
  always_comb begin
    bus.if_pred_branch = 1'b0;
    bus.if_pred_taken  = 1'b0;
    bus.if_pred_npc    = bus.if_pc + 32'd4;
    if (bus.flush) begin
      bus.if_pred_npc = flush_npc;
    end else if (bus.if_pc == TAKEN_PC) begin
      bus.if_pred_branch = 1'b1;
      bus.if_pred_taken  = 1'b1;
      bus.if_pred_npc    = TAKEN_TGT;
    end
  end

  // Synchronous ROM: word appears the cycle after the request.
  always @(posedge clk) begin
    bus.imem_rdata <= bus.imem_en ? rom(bus.if_pc) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input logic [31:0] pc);
    logic br;
    br = (pc == TAKEN_PC);
    check("id_valid", {31'd0, bus.id_valid}, 32'd1);
    check("id_pc", bus.id_pc, pc);
    check("id_inst", bus.id_inst, rom(pc));
    check("id_pred_branch", {31'd0, bus.id_pred_branch}, {31'd0, br});
    check("id_pred_taken", {31'd0, bus.id_pred_taken}, {31'd0, br});
    check("id_pred_npc", bus.id_pred_npc, br ? TAKEN_TGT : pc + 32'd4);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_id_valid"}, {31'd0, bus.id_valid}, 32'd0);
    check({tag, "_id_pc"}, bus.id_pc, 32'd0);
    check({tag, "_id_inst"}, bus.id_inst, 32'd0);
    check({tag, "_id_meta"}, {30'd0, bus.id_pred_branch, bus.id_pred_taken}, 32'd0);
    check({tag, "_id_npc"}, bus.id_pred_npc, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seq_a [7];
    logic [31:0] seq_c [7];
    seq_a = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_000C,
              32'hBFC0_0010, 32'hBFC0_0100, 32'hBFC0_0104};
    seq_c = '{32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_000C, 32'hBFC0_0010,
              32'hBFC0_0100, 32'hBFC0_0104, 32'hBFC0_0108};
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b1;
    flush_npc = 32'h0;

    // Reset state.
    settle();
    check("rst_if_pc", bus.if_pc, RESET_PC);
    check("rst_imem_en", {31'd0, bus.imem_en}, 32'd0);
    check_empty("rst");
    cyc();
    cyc();
    rst = 1'b0;
    settle();
    check("first_issue", {31'd0, bus.imem_en}, 32'd1);
    check("first_if_pc", bus.if_pc, RESET_PC);
    cyc();
    settle();
    check("no_bypass", {31'd0, bus.id_valid}, 32'd0);
    check("second_if_pc", bus.if_pc, 32'hBFC0_0004);
    cyc();
    settle();

    // Sequential stream through a predicted-taken branch.
    for (int i = 0; i < 7; i++) begin
      check_head(seq_a[i]);
      cyc();
      settle();
    end

    // Reset mid-stream, then backpressure from empty.
    cyc();
    rst = 1'b1;
    bus.id_ready = 1'b0;
    cyc();
    rst = 1'b0;
    settle();
    check("bp_if_pc", bus.if_pc, RESET_PC);
    check("bp_empty", {31'd0, bus.id_valid}, 32'd0);
    check("bp_issue0", {31'd0, bus.imem_en}, 32'd1);
    n_issue = 1;
    for (int i = 1; i < 10; i++) begin
      cyc();
      settle();
      if (bus.imem_en) n_issue++;
      if (i >= 2) check("bp_head_stable", bus.id_pc, RESET_PC);
    end
    check("bp_issue_count", n_issue, 32'd4);

    // Single-cycle pop: exactly one new issue, on the following cycle.
    cyc();
    bus.id_ready = 1'b1;
    settle();
    check("pop_head", bus.id_pc, RESET_PC);
    check("pop_no_issue", {31'd0, bus.imem_en}, 32'd0);
    cyc();
    bus.id_ready = 1'b0;
    settle();
    check("resume_issue", {31'd0, bus.imem_en}, 32'd1);
    check("resume_if_pc", bus.if_pc, TAKEN_PC);
    check("resume_head", bus.id_pc, 32'hBFC0_0004);
    cyc();
    bus.id_ready = 1'b1;
    settle();
    check("restall", {31'd0, bus.imem_en}, 32'd0);

    // Push and pop together at count=3 with pointers wrapping.
    for (int i = 0; i < 7; i++) begin
      check_head(seq_c[i]);
      cyc();
      settle();
    end

    // Fill to 3 queued + 1 in flight, then flush with a ready decode.
    cyc();
    bus.id_ready = 1'b0;
    settle();
    check("pre_flush_issue", {31'd0, bus.imem_en}, 32'd1);
    cyc();
    bus.flush    = 1'b1;
    flush_npc    = FLUSH_TGT;
    bus.id_ready = 1'b1;
    settle();
    check("flush_imem_en", {31'd0, bus.imem_en}, 32'd0);
    check("flush_head_valid", {31'd0, bus.id_valid}, 32'd1);
    cyc();
    bus.flush = 1'b0;
    settle();
    check("redirect_if_pc", bus.if_pc, FLUSH_TGT);
    check("redirect_issue", {31'd0, bus.imem_en}, 32'd1);
    check_empty("flush_t1");
    cyc();
    settle();
    check_empty("flush_t2");
    cyc();
    settle();
    check_head(FLUSH_TGT);
    cyc();
    settle();
    check_head(FLUSH_TGT + 32'd4);

    // Reset and flush together: reset wins.
    cyc();
    rst       = 1'b1;
    bus.flush = 1'b1;
    flush_npc = 32'h1234_5678;
    cyc();
    rst       = 1'b0;
    bus.flush = 1'b0;
    settle();
    check("rstflush_if_pc", bus.if_pc, RESET_PC);
    check("rstflush_issue", {31'd0, bus.imem_en}, 32'd1);
    check_empty("rstflush");
    cyc();
    settle();
    check("rstflush_t1_valid", {31'd0, bus.id_valid}, 32'd0);
    cyc();
    settle();
    check_head(RESET_PC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
